dmem_responder: RTL
===================

# dmem_responder

Data-memory responder on the core's D-memory port: accepts single-cycle requests (chip select, write enable, 5-bit byte-enable, address, write data) and services them against an internal word-organised byte-writable array. It performs store lane placement, load lane extraction with sign/zero extension, access counting and error flagging. It sits where a bare data SRAM sits today, so the core receives load data already extended and LSB-aligned.

## Interface
Parameters:
- AWIDTH, 12: byte-address width; array holds 2^(AWIDTH-2) words.
- INIT_FILE, "": optional $readmemh image; empty means contents are uninitialised.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  reset; asynchronous, active-low.
- D_MEM_CSN  in  1  request strobe, active-low; one request per cycle.
- D_MEM_WEN  in  1  0 = write, 1 = read.
- D_MEM_BE  in  5  [3:0] byte lanes of aligned word; [4] = 1 zero-extend load, 0 sign-extend.
- D_MEM_ADDR  in  32  byte address; [1:0] ignored, lanes come from BE.
- D_MEM_DI  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- D_MEM_DOUT  out  32  load data, LSB-aligned, extended.
- ERR  out  1  sticky error flag.
- RD_CNT  out  32  completed legal reads.
- WR_CNT  out  32  completed legal writes.

## Operation
- Legal BE[3:0]: 0001, 0010, 0100, 1000 (byte); 0011, 1100 (half); 1111 (word). All others illegal.
- Out of range: any of ADDR[31:AWIDTH] set.
- Write (CSN=0, WEN=0, legal, in range): byte → DI[7:0] replicated to all lanes; half → DI[15:0] to both halves; word → DI. Only enabled lanes of word ADDR[AWIDTH-1:2] updated. WR_CNT += 1.
- Read (CSN=0, WEN=1, legal, in range): word fetched; enabled lanes shifted to bit 0; bits above width filled with 0 (BE[4]=1) or MSB of selected field (BE[4]=0). BE[4] ignored for word reads. RD_CNT += 1.
- Illegal or out-of-range request: array untouched, counters unchanged, ERR set; read of this kind drives DOUT = 0.
- BE[4] ignored on writes.
- ERR cleared only by reset.
- Idle (CSN=1): no state change; DOUT holds last value.
- Counters wrap 0xFFFFFFFF → 0 silently.

## Timing
- Request sampled on rising edge; read result on DOUT after that same edge (one-cycle latency), held until next read completes.
- Write at edge N visible to read sampled at edge N+1 (write-then-read same word returns new data).
- Array read and write never occur in same cycle (single port).
- ERR and counters update on same edge as request.
- Reset values: DOUT = 0, ERR = 0, RD_CNT = 0, WR_CNT = 0. Array not reset.
- Reset asserted mid-sequence: pending read result discarded, DOUT forced 0 immediately; a write sampled on the same edge RSTn rises is ignored (reset dominant until deasserted before edge).

## Structure
- Shared package: BE lane-pattern constants (byte/half/word masks), extension-mode bit index, legal-pattern check function.
- Sub-module dmem_load_align: combinational lane extract + sign/zero extend from registered word, registered BE; responder owns array, request decode, counters, ERR.
- Registered request info (BE, legal, read flag) carried one stage to align with array output.

## Test plan
- Write 0x11223344 BE=01111 to 0x10, read BE=01111 → DOUT 0x11223344; WR_CNT=1, RD_CNT=1.
- Write DI=0x000000F0 BE=00100 to 0x10, read BE=00100 → 0xFFFFFFF0; BE=10100 → 0x000000F0; word read → 0x11F03344.
- Half write DI=0x8001 BE=01100 to 0x20, read BE=01100 → 0xFFFF8001, BE=11100 → 0x00008001.
- Illegal BE=00101 write to 0x10 → word unchanged, ERR=1, WR_CNT unchanged; out-of-range read addr 0x1000 (AWIDTH=12) → DOUT 0, ERR stays 1.
- Back-to-back write 0xA5A5A5A5 then read same word next cycle → 0xA5A5A5A5; idle cycles keep DOUT stable.
- Assert RSTn=0 between read request edge and next edge → DOUT 0, counters 0, ERR 0 asynchronously; array contents preserved after release.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared byte-enable encodings and decode helpers for the D-memory responder.
// Pure definitions: no latency, no flow control.
package dmem_responder_pkg;

    localparam int BE_EXT_BIT = 4;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    function automatic acc_size_e be_size(input logic [3:0] be);
        acc_size_e sz;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: sz = SZ_BYTE;
            BE_H0, BE_H1:               sz = SZ_HALF;
            BE_W:                       sz = SZ_WORD;
            default:                    sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic be_legal(input logic [3:0] be);
        return be_size(be) != SZ_NONE;
    endfunction

    // Index of the lowest enabled lane; only meaningful for legal patterns.
    function automatic logic [1:0] be_lane(input logic [3:0] be);
        logic [1:0] lane;
        case (be)
            BE_B1:        lane = 2'd1;
            BE_B2, BE_H1: lane = 2'd2;
            BE_B3:        lane = 2'd3;
            default:      lane = 2'd0;
        endcase
        return lane;
    endfunction

    // Replicate LSB-aligned store data so every enabled lane sees its field.
    function automatic logic [31:0] store_lanes(input logic [3:0] be, input logic [31:0] di);
        logic [31:0] data;
        case (be_size(be))
            SZ_BYTE: data = {4{di[7:0]}};
            SZ_HALF: data = {2{di[15:0]}};
            default: data = di;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the enabled lanes of a fetched word, LSB-aligns and sign/zero extends.
// Purely combinational; no flow control, output follows inputs.
module dmem_load_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [4:0]  i_be,
    input  logic        i_vld,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic        w_zext;
    acc_size_e   w_size;

    always_comb begin
        w_size    = be_size(i_be[3:0]);
        w_shifted = i_word >> {be_lane(i_be[3:0]), 3'b000};
        w_zext    = i_be[BE_EXT_BIT];
        o_data    = '0;
        if (i_vld) begin
            case (w_size)
                SZ_BYTE: o_data = {{24{~w_zext & w_shifted[7]}}, w_shifted[7:0]};
                SZ_HALF: o_data = {{16{~w_zext & w_shifted[15]}}, w_shifted[15:0]};
                SZ_WORD: o_data = i_word;
                default: o_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Byte-writable data memory with lane placement, extended loads, counters and sticky error.
// One-cycle read latency; no backpressure, one request accepted every cycle.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int    AWIDTH    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        D_MEM_CSN,
    input  logic        D_MEM_WEN,
    input  logic [4:0]  D_MEM_BE,
    input  logic [31:0] D_MEM_ADDR,
    input  logic [31:0] D_MEM_DI,
    output logic [31:0] D_MEM_DOUT,
    output logic        ERR,
    output logic [31:0] RD_CNT,
    output logic [31:0] WR_CNT
);

    localparam int DEPTH = 1 << (AWIDTH - 2);
    localparam bit lp_init_unused = (INIT_FILE != "");

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rdata;
    logic [4:0]        r_be;
    logic              r_rd_ok;
    logic              r_err;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;

    logic              w_req;
    logic              w_legal;
    logic              w_in_range;
    logic              w_ok;
    logic              w_wr;
    logic              w_rd;
    logic [AWIDTH-3:0] w_idx;
    logic [31:0]       w_wdata;
    logic              w_addr_lsb_unused;

    assign w_req             = ~D_MEM_CSN;
    assign w_legal           = be_legal(D_MEM_BE[3:0]);
    assign w_in_range        = ~|D_MEM_ADDR[31:AWIDTH];
    assign w_ok              = w_legal & w_in_range;
    // Gating with RSTn keeps a write presented while reset is held out of the array.
    assign w_wr              = w_req & ~D_MEM_WEN & w_ok & RSTn;
    assign w_rd              = w_req & D_MEM_WEN & w_ok;
    assign w_idx             = D_MEM_ADDR[AWIDTH-1:2];
    assign w_wdata           = store_lanes(D_MEM_BE[3:0], D_MEM_DI);
    assign w_addr_lsb_unused = ^D_MEM_ADDR[1:0];

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (D_MEM_BE[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
        if (w_rd) begin
            r_rdata <= r_mem[w_idx];
        end
    end

    // Read-side context only moves on read requests so DOUT holds across idles and writes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rd_ok  <= 1'b0;
            r_be     <= '0;
            r_err    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_req && D_MEM_WEN) begin
                r_rd_ok <= w_ok;
                r_be    <= D_MEM_BE;
            end
            if (w_req && !w_ok) begin
                r_err <= 1'b1;
            end
            if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    dmem_load_align u_align (
        .i_word (r_rdata),
        .i_be   (r_be),
        .i_vld  (r_rd_ok),
        .o_data (D_MEM_DOUT)
    );

    assign ERR    = r_err;
    assign RD_CNT = r_rd_cnt;
    assign WR_CNT = r_wr_cnt;

endmodule
